// File: rtl/uart_bit_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_bit_sampler                                             |
// | Description : Receive-side bit sampler. Synchronises the RX line, qualifies |
// |               the start bit at half-bit, samples DATA_BITS data bits        |
// |               LSB-first at mid-bit, checks the stop bit and emits a         |
// |               parallel word with one-clk valid / framing-error strobes.     |
// | Options     : `define UART_BIT_SAMPLER_MAJORITY_EN for 2-of-3 majority      |
// |               sampling around every sample point.                           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module uart_bit_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_sample_en,
  input  logic                 i_rx_in,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int               BIT_W      = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_BIT_SAMPLER_MAJORITY_EN
  // The vote completes one tick after the nominal point, so the start check
  // lands one count later and the bit counter restarts at 1.
  localparam logic [CNT_W-1:0] c_START_PT = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] c_RELOAD   = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] c_START_PT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] c_RELOAD   = CNT_W'(0);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [BIT_W-1:0]     w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 r_busy;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  logic                 w_sample;
  logic                 w_bit_pt;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

`ifdef UART_BIT_SAMPLER_MAJORITY_EN
  logic r_hist1;
  logic r_hist2;
  logic r_pend;

  // Keep the last two ticked line samples for the 2-of-3 vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist1 <= 1'b1;
      r_hist2 <= 1'b1;
    end else if (i_sample_en) begin
      r_hist1 <= w_rx_s;
      r_hist2 <= r_hist1;
    end
  end

  // Flag the tick after cnt==OVERSAMPLE-1 as the decision tick for data/stop bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else if (i_sample_en) begin
      r_pend <= ((r_state == S_DATA) || (r_state == S_STOP)) &&
                !r_pend && (r_cnt == c_CNT_LAST);
    end
  end

  assign w_sample = (r_hist2 & r_hist1) | (r_hist2 & w_rx_s) | (r_hist1 & w_rx_s);
  assign w_bit_pt = r_pend;
`else
  assign w_sample = w_rx_s;
  assign w_bit_pt = (r_cnt == c_CNT_LAST);
`endif

  // Next-state, counter, shift-register and strobe decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    if (i_sample_en) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
          end
        end
        S_START: begin
          if (r_cnt == c_START_PT) begin
            if (!w_sample) begin
              w_state_nxt   = S_DATA;
              w_cnt_nxt     = c_RELOAD;
              w_bit_idx_nxt = '0;
            end else begin
              // Start bit did not hold to half-bit: treat as a glitch
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_pt) begin
            w_shift_nxt = {w_sample, r_shift[DATA_BITS-1:1]};
            w_cnt_nxt   = c_RELOAD;
            if (r_bit_idx == c_BIT_LAST) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
            end
          end else if (r_cnt == c_CNT_LAST) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_pt) begin
            w_cnt_nxt = '0;
            if (w_sample) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              // Hold off in BREAK so a line stuck low cannot start a new frame
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end else if (r_cnt == c_CNT_LAST) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters, output word and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_data_out   = r_data;
  assign o_data_valid = r_valid;
  assign o_frame_err  = r_ferr;
  assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_bit_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_bit_sampler                                          |
// | Description : Directed self-checking bench for uart_bit_sampler            |
// |               (OVERSAMPLE=16, DATA_BITS=8, sample_en every 4th clk).       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_bit_sampler;

`ifdef UART_BIT_SAMPLER_MAJORITY_EN
  localparam int c_LAT       = 153;
  localparam int c_START_DEC = 9;
`else
  localparam int c_LAT       = 152;
  localparam int c_START_DEC = 8;
`endif

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       sample_en = 1'b0;
  logic       rx_in     = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int tk       = 0;
  int div      = 0;
  int dv_cnt   = 0;
  int fe_cnt   = 0;
  int dv_tick  = -1;
  int fe_tick  = -1;
  bit dv_wide  = 1'b0;
  bit fe_wide  = 1'b0;
  bit both     = 1'b0;
  bit dv_prev  = 1'b0;
  bit fe_prev  = 1'b0;
  logic [7:0] dv_data[$];
  int         dv_ticks[$];

  uart_bit_sampler #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sample_en  (sample_en),
    .i_rx_in      (rx_in),
    .o_data_out   (data_out),
    .o_data_valid (data_valid),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Oversample tick: one clk in every four
  initial begin
    forever begin
      @(negedge clk);
      sample_en = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Tick number of the most recent tick edge
  always @(posedge clk) begin
    if (sample_en) tk++;
  end

  // Strobe bookkeeping, sampled on the falling edge
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_tick = tk;
      dv_data.push_back(data_out);
      dv_ticks.push_back(tk);
      if (dv_prev) dv_wide = 1'b1;
    end
    if (frame_err) begin
      fe_cnt++;
      fe_tick = tk;
      if (fe_prev) fe_wide = 1'b1;
    end
    if (data_valid && frame_err) both = 1'b1;
    dv_prev = data_valid;
    fe_prev = frame_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired tk=%0d required=finish", tk);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    while (!sample_en) @(posedge clk);
    #1;
  endtask

  // Drives a frame one tick at a time; rx_s on tick t0+i equals the value set at step i
  task automatic send_frame(input logic [7:0] b, input int stop_ticks, input logic stop_val,
                            input bit glitch, output int t0);
    t0 = tk + 1;
    for (int i = 0; i < 144 + stop_ticks; i++) begin
      int   j;
      int   t;
      logic v;
      j = i / 16;
      t = i % 16;
      if (j == 0) v = 1'b0;
      else if (j <= 8) v = b[j-1];
      else v = stop_val;
      if (glitch && (j >= 1) && (j <= 8) && (t == 8)) v = ~v;
      rx_in = v;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", data_out); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_ferr got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic_frame();
    int t0;
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'hA5, 16, 1'b1, 1'b0, t0);
    checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL t1_data got=%h exp=a5", data_out); end
    checks++; if (dv_cnt !== dv0 + 1) begin failures++; $display("FAIL t1_dv_count got=%0d exp=%0d", dv_cnt, dv0 + 1); end
    checks++; if (dv_tick !== t0 + c_LAT) begin failures++; $display("FAIL t1_dv_tick got=%0d exp=%0d", dv_tick, t0 + c_LAT); end
    checks++; if (fe_cnt !== fe0) begin failures++; $display("FAIL t1_ferr got=%0d exp=%0d", fe_cnt, fe0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_glitch();
    int t0;
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    t0  = tk + 1;
    for (int i = 0; i < 5; i++) begin
      rx_in = 1'b0;
      tick();
    end
    rx_in = 1'b1;
    while (tk < t0 + c_START_DEC - 1) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t2_busy_before got=%b exp=1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_busy_reject got=%b exp=0", busy); end
    repeat (20) tick();
    checks++; if (dv_cnt !== dv0) begin failures++; $display("FAIL t2_no_valid got=%0d exp=%0d", dv_cnt, dv0); end
    checks++; if (fe_cnt !== fe0) begin failures++; $display("FAIL t2_no_ferr got=%0d exp=%0d", fe_cnt, fe0); end
    checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL t2_data_kept got=%h exp=a5", data_out); end
  endtask

  task automatic test_frame_error();
    int t0;
    int t1;
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h3C, 40, 1'b0, 1'b0, t0);
    checks++; if (fe_cnt !== fe0 + 1) begin failures++; $display("FAIL t3_fe_count got=%0d exp=%0d", fe_cnt, fe0 + 1); end
    checks++; if (fe_tick !== t0 + c_LAT) begin failures++; $display("FAIL t3_fe_tick got=%0d exp=%0d", fe_tick, t0 + c_LAT); end
    checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL t3_data_kept got=%h exp=a5", data_out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t3_busy_break got=%b exp=1", busy); end
    rx_in = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t3_busy_idle got=%b exp=0", busy); end
    checks++; if (dv_cnt !== dv0) begin failures++; $display("FAIL t3_no_valid got=%0d exp=%0d", dv_cnt, dv0); end
    repeat (3) tick();
    send_frame(8'h81, 16, 1'b1, 1'b0, t1);
    checks++; if (data_out !== 8'h81) begin failures++; $display("FAIL t3_next_data got=%h exp=81", data_out); end
    checks++; if (dv_tick !== t1 + c_LAT) begin failures++; $display("FAIL t3_next_tick got=%0d exp=%0d", dv_tick, t1 + c_LAT); end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    int n;
    send_frame(8'h00, 16, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 16, 1'b1, 1'b0, t1);
    n = dv_ticks.size();
    checks++; if (n < 2) begin failures++; $display("FAIL t4_pulses got=%0d exp>=2", n); end
    if (n >= 2) begin
      checks++; if (dv_ticks[n-2] !== t0 + c_LAT) begin failures++; $display("FAIL t4_first_tick got=%0d exp=%0d", dv_ticks[n-2], t0 + c_LAT); end
      checks++; if (dv_ticks[n-1] - dv_ticks[n-2] !== 160) begin failures++; $display("FAIL t4_spacing got=%0d exp=160", dv_ticks[n-1] - dv_ticks[n-2]); end
      checks++; if (dv_data[n-2] !== 8'h00) begin failures++; $display("FAIL t4_first_data got=%h exp=00", dv_data[n-2]); end
      checks++; if (dv_data[n-1] !== 8'hFF) begin failures++; $display("FAIL t4_second_data got=%h exp=ff", dv_data[n-1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    int t1;
    int dv0;
    int fe0;
    logic [7:0] b;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    b   = 8'hC3;
    t0  = tk + 1;
    for (int i = 0; i <= 70; i++) begin
      int j;
      j = i / 16;
      rx_in = (j == 0) ? 1'b0 : b[j-1];
      tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL t5_async_data got=%h exp=00", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_async_busy got=%b exp=0", busy); end
    checks++; if ((data_valid | frame_err) !== 1'b0) begin failures++; $display("FAIL t5_async_strobes got=%b%b exp=00", data_valid, frame_err); end
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) tick();
    checks++; if (dv_cnt !== dv0) begin failures++; $display("FAIL t5_no_valid got=%0d exp=%0d", dv_cnt, dv0); end
    checks++; if (fe_cnt !== fe0) begin failures++; $display("FAIL t5_no_ferr got=%0d exp=%0d", fe_cnt, fe0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_idle got=%b exp=0", busy); end
    send_frame(8'h5A, 16, 1'b1, 1'b0, t1);
    checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL t5_next_data got=%h exp=5a", data_out); end
    checks++; if (dv_tick !== t1 + c_LAT) begin failures++; $display("FAIL t5_next_tick got=%0d exp=%0d", dv_tick, t1 + c_LAT); end
  endtask

`ifdef UART_BIT_SAMPLER_MAJORITY_EN
  task automatic test_majority();
    int t0;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h55, 16, 1'b1, 1'b1, t0);
    checks++; if (data_out !== 8'h55) begin failures++; $display("FAIL t6_data got=%h exp=55", data_out); end
    checks++; if (dv_tick !== t0 + c_LAT) begin failures++; $display("FAIL t6_dv_tick got=%0d exp=%0d", dv_tick, t0 + c_LAT); end
    checks++; if (fe_cnt !== fe0) begin failures++; $display("FAIL t6_ferr got=%0d exp=%0d", fe_cnt, fe0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_BIT_SAMPLER_MAJORITY_EN
    test_majority();
`endif
    checks++; if (dv_wide !== 1'b0) begin failures++; $display("FAIL valid_width got=wide exp=one_clk"); end
    checks++; if (fe_wide !== 1'b0) begin failures++; $display("FAIL ferr_width got=wide exp=one_clk"); end
    checks++; if (both !== 1'b0) begin failures++; $display("FAIL strobe_exclusive got=both exp=one"); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_bit_sampler.md
Name: uart_bit_sampler

Overview:
- Parametrised receive-side bit sampler for the serial character detector.
- Synchronises the raw RX line and detects and qualifies the start bit at half-bit.
- Samples DATA_BITS data bits LSB-first at mid-bit using a programmable oversample ratio, then checks the stop bit.
- Feeds the character identifier with a parallel word plus valid/error strobes. Replaces the fixed 16-count sampler.

Parameters:
- OVERSAMPLE, 16, sample_en ticks per bit period; even, >= 4.
- DATA_BITS, 8, data bits per character; 5..9.
- CNT_W, $clog2(OVERSAMPLE), tick counter width; derived, do not override.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_en  in  1  oversample tick; one-clk pulse, OVERSAMPLE per bit period.
- rx_in  in  1  raw serial line; idle high, asynchronous to clk.
- data_out  out  DATA_BITS  last good character, LSB = first received bit.
- data_valid  out  1  one-clk pulse; data_out updated this cycle.
- frame_err  out  1  one-clk pulse; stop bit sampled low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0), all held while low:
  - data_out=0, data_valid=0, frame_err=0, busy=0.
  - State=IDLE, tick cnt=0, bit_idx=0, shift reg=0.
  - Sync flops=1 (line idle).
- Sync: rx_in passes through a 2-flop synchroniser -> rx_s. All decisions use rx_s only.
- Counters advance only on clocks with sample_en=1. With sample_en=0 the FSM holds; strobes are still cleared.
- FSM states:
  - IDLE: on a tick with rx_s=0 -> START, cnt=0. That tick is T0.
  - START: cnt++ per tick. On the tick with cnt==OVERSAMPLE/2-1 (T0+OVERSAMPLE/2):
    - rx_s=0 -> DATA, cnt=0, bit_idx=0.
    - rx_s=1 -> IDLE (glitch rejected; no strobe).
  - DATA: cnt++ per tick. On the tick with cnt==OVERSAMPLE-1:
    - shift rx_s in at the MSB, shifting right (LSB-first assembly); cnt=0.
    - if bit_idx==DATA_BITS-1 -> STOP, else bit_idx++.
    - Data bit k is sampled at T0+OVERSAMPLE/2+OVERSAMPLE*(k+1).
  - STOP: on the tick with cnt==OVERSAMPLE-1 (T0+OVERSAMPLE/2+OVERSAMPLE*(DATA_BITS+1)):
    - rx_s=1: data_out<=shift reg, data_valid=1 for the next clk only, -> IDLE.
    - rx_s=0: frame_err=1 for the next clk only, data_out unchanged, -> BREAK.
  - BREAK: wait for a tick with rx_s=1 -> IDLE. Prevents a held-low line retriggering START.
- Strobes: data_valid and frame_err are mutually exclusive, registered, exactly one clk wide.
- Back-to-back characters: a start edge on the first tick after returning to IDLE is accepted. No dead time beyond one tick.
- Counter rules:
  - cnt compares are exact equality; cnt never exceeds OVERSAMPLE-1.
  - bit_idx width $clog2(DATA_BITS+1); no wrap past DATA_BITS-1.
- Reset mid-character: the partial character is discarded, no strobe fires, and the FSM restarts in IDLE after rst_n deasserts.
- busy rises the clk after T0 and falls the clk the FSM re-enters IDLE.

Optional Feature:
- Macro: UART_BIT_SAMPLER_MAJORITY_EN.
- Defined:
  - Each data and stop sample is the 2-of-3 majority of rx_s on ticks cnt==OVERSAMPLE-2, OVERSAMPLE-1 and the following tick.
  - The decision is made on the third tick, so all sample points shift one tick later. cnt is reloaded to 1 instead of 0 so bit period stays OVERSAMPLE.
  - The start check uses the majority of cnt==OVERSAMPLE/2-2..OVERSAMPLE/2.
- Undefined: single-point sampling as specified above. The majority logic and its two extra history flops are absent.

Test Plan:
All cases use OVERSAMPLE=16, DATA_BITS=8, sample_en every 4th clk, macro undefined unless stated.
1. Frame start(0), bits of 0xA5 LSB-first, stop(1) -> data_out=0xA5; data_valid one clk after tick T0+152; frame_err=0; busy low afterwards.
2. rx_in low for 5 ticks then high (glitch) -> FSM returns to IDLE at T0+8; no data_valid, no frame_err; data_out keeps its previous value.
3. Frame 0x3C with stop bit held low for 40 ticks -> frame_err pulse one clk after T0+152; data_out unchanged. No new START until rx_in is high, then a following 0x81 frame gives data_valid with data_out=0x81.
4. Two back-to-back frames 0x00 then 0xFF, with the next start immediately after the stop bit -> two data_valid pulses exactly 160 ticks apart; data_out=0x00 then 0xFF.
5. rst_n pulsed low at T0+70 during a frame -> all outputs 0 asynchronously, state IDLE. No strobe for that frame; the next full frame 0x5A is received correctly.
6. Macro defined; frame 0x55 with a single-tick inverted glitch at each data-bit centre -> data_out=0x55, data_valid asserted, frame_err=0.
